clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Time-setting controller for the digital-clock counter chain (hour/minute/second BCD digits q5..q0).
- Debounces the three active-low pushbuttons.
- Runs a mode FSM: RUN, then set hours, set minutes, set seconds.
- Gates the chain's run enable and issues one-cycle increment/decrement strobes to the selected field.
- Drives a per-digit blink/blank mask for the display path.

Parameters:
- DB_COUNT, 4: consecutive stable synchronized samples required to accept a button level (1..255).
- BLINK_DIV, 8: clk_in cycles per blink half-period in set modes (2..65535).
- TIMEOUT_TICKS, 3: tick_in pulses with no accepted press before a set mode returns to RUN (1..255).
- REPEAT_CYCLES, 16: auto-repeat period in clk_in cycles; used only with AUTO_REPEAT_EN.

Ports:
- clk_in, in, 1: single system clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- pb_mode_n, in, 1: mode button, active low, asynchronous raw.
- pb_inc_n, in, 1: increment button, active low, raw.
- pb_dec_n, in, 1: decrement button, active low, raw.
- tick_in, in, 1: one-cycle 1 Hz enable from the prescaler.
- mode, out, 2: 00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC.
- run_en, out, 1: counter chain may count on tick_in.
- adj_sel, out, 2: field for adjust strobes; equals mode.
- adj_up, out, 1: one-cycle increment strobe to the selected field.
- adj_dn, out, 1: one-cycle decrement strobe to the selected field.
- blank, out, 6: 1 blanks the digit; bit5..0 map to q5..q0.

Behaviour:
Reset:
- mode=00, run_en=1, adj_sel=00, adj_up=0, adj_dn=0, blank=000000.
- Sync flops, debounced levels and press history reset to 1 (released); all counters reset to 0.
- A reset asserted mid-set-mode aborts to RUN on the same edge; no strobe is emitted that cycle.

Input conditioning, per button:
- 2-flop synchronizer, then a stable counter. The accepted level changes only after DB_COUNT consecutive equal synchronized samples differing from the current accepted level.
- Press event: one-cycle pulse on an accepted 1->0 transition. Releases generate nothing.
- Edge sampled low at edge N (raw held low throughout) gives the press pulse high in the cycle after edge N+1+DB_COUNT.
- Registered outputs (mode, adj_up/adj_dn) change on the next edge, i.e. N+2+DB_COUNT.
- A glitch shorter than DB_COUNT samples produces no event.

FSM, advanced by mode-press:
- RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
- In RUN: run_en=1 and inc/dec presses are ignored.
- In set states: run_en=0. An inc press gives adj_up=1 for exactly one cycle; a dec press gives adj_dn=1 for exactly one cycle. adj_sel=mode.
- Inc and dec presses in the same cycle: both dropped.
- Mode press together with inc/dec in the same cycle: mode advance wins, and the adjust press is dropped.
- Wrap and saturation of the field value belong to the counter chain, not this block.

Timeout:
- Counter clears on entering a set state and on any accepted press.
- Increments on tick_in while in a set state.
- Reaching TIMEOUT_TICKS forces mode=RUN and run_en=1 on that edge.
- A press coinciding with the final tick is honoured (counter clears) and no timeout occurs.

Blink:
- Phase flag clears and the divider restarts on set-state entry and on every adj_up/adj_dn.
- Phase toggles every BLINK_DIV cycles.
- blank: in RUN always 0; in a set state, the selected field's two digits equal the phase (SET_HR bits5:4, SET_MIN 3:2, SET_SEC 1:0), other digits 0.

Optional Feature:
AUTO_REPEAT_EN
- Defined: while inc (or dec) stays accepted-low in a set state, a further adj_up (adj_dn) fires every REPEAT_CYCLES cycles after the initial press strobe. Each repeat clears the timeout counter and restarts blink. Releasing the button, or pressing both buttons, stops repeats immediately.
- Undefined: exactly one strobe per press; REPEAT_CYCLES unused.

Test Plan (DB_COUNT=4, BLINK_DIV=8, TIMEOUT_TICKS=3):
- Reset held 2 cycles, buttons high -> mode=00, run_en=1, blank=000000, no strobes.
- pb_mode_n low from edge 10 -> mode=01, run_en=0 at edge 16. Three further presses step 10 -> 11 -> 00. run_en=1 back in RUN.
- In SET_MIN, pb_inc_n low 3 cycles -> no adj_up. Low 20 cycles -> exactly one adj_up pulse with adj_sel=10; release produces none.
- In SET_HR, no presses -> blank toggles 110000/000000 every 8 cycles. Third tick_in -> mode=00, blank=000000.
- Inc and dec accepted same cycle -> no strobe. Mode+inc same cycle -> mode advances, no adj_up.
- rst during SET_SEC with inc pending -> mode=00, run_en=1, no adj_up. With AUTO_REPEAT_EN and REPEAT_CYCLES=16, holding inc 50 cycles after the first strobe -> 3 additional adj_up pulses, spaced 16 cycles apart.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Time-setting controller for the digital-clock counter chain (q5..q0 =
// HH:MM:SS BCD digits). Debounces three active-low pushbuttons, runs the
// RUN -> SET_HR -> SET_MIN -> SET_SEC mode machine, gates the chain's run
// enable, issues one-cycle adjust strobes and drives the digit blank mask.
//
// Optional feature macro: AUTO_REPEAT_EN (held inc/dec auto-repeats every
// REPEAT_CYCLES cycles in set modes). Undefined: one strobe per press.
//
// Ports:
//   clk_in    in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   pb_mode_n in   raw mode button, active low
//   pb_inc_n  in   raw increment button, active low
//   pb_dec_n  in   raw decrement button, active low
//   tick_in   in   one-cycle 1 Hz enable
//   mode      out  00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC
//   run_en    out  counter chain may count
//   adj_sel   out  field selected for adjust strobes (equals mode)
//   adj_up    out  one-cycle increment strobe
//   adj_dn    out  one-cycle decrement strobe
//   blank     out  per-digit blank mask, bit5..0 -> q5..q0
module clock_set_ctrl #(
  parameter int unsigned DB_COUNT      = 4,
  parameter int unsigned BLINK_DIV     = 8,
  parameter int unsigned TIMEOUT_TICKS = 3,
  parameter int unsigned REPEAT_CYCLES = 16
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       pb_mode_n,
  input  logic       pb_inc_n,
  input  logic       pb_dec_n,
  input  logic       tick_in,
  output logic [1:0] mode,
  output logic       run_en,
  output logic [1:0] adj_sel,
  output logic       adj_up,
  output logic       adj_dn,
  output logic [5:0] blank
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_SET_SEC = 2'b11
  } state_t;

  localparam logic [7:0]  DB_LAST    = 8'(DB_COUNT - 1);
  localparam logic [7:0]  TO_LAST    = 8'(TIMEOUT_TICKS - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_DIV - 1);

  // Reject out-of-range configurations at elaboration time.
  generate
    if (DB_COUNT < 1 || DB_COUNT > 255) begin : g_bad_db
      $error("DB_COUNT out of range 1..255");
    end
    if (BLINK_DIV < 2 || BLINK_DIV > 65535) begin : g_bad_blink
      $error("BLINK_DIV out of range 2..65535");
    end
    if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_to
      $error("TIMEOUT_TICKS out of range 1..255");
    end
    if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65535) begin : g_bad_rep
      $error("REPEAT_CYCLES out of range 1..65535");
    end
  endgenerate

  // Button index: 0 = mode, 1 = inc, 2 = dec.
  logic [2:0] raw_s;
  logic [2:0] sync1_r;
  logic [2:0] sync2_r;
  logic [2:0] level_r;   // accepted (debounced) level, 1 = released
  logic [2:0] hist_r;    // accepted level one cycle ago
  logic [7:0] db_cnt_r [3];
  logic [2:0] press_s;

  assign raw_s = {pb_dec_n, pb_inc_n, pb_mode_n};

  // Synchronizers and stable-sample counters for all three buttons.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
      level_r <= 3'b111;
      hist_r  <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        db_cnt_r[i] <= 8'd0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      hist_r  <= level_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != level_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            level_r[i]  <= sync2_r[i];
            db_cnt_r[i] <= 8'd0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + 8'd1;
          end
        end else begin
          db_cnt_r[i] <= 8'd0;
        end
      end
    end
  end

  // Press = accepted 1->0; combinational so the registered outputs react on
  // the very next edge.
  assign press_s = hist_r & ~level_r;

  logic mode_press_s;
  logic inc_press_s;
  logic dec_press_s;
  assign mode_press_s = press_s[0];
  assign inc_press_s  = press_s[1];
  assign dec_press_s  = press_s[2];

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  to_cnt_r;
  logic [7:0]  to_cnt_s;
  logic [15:0] div_r;
  logic [15:0] div_s;
  logic        phase_r;
  logic        phase_s;
  logic        up_s;
  logic        dn_s;
  logic        entry_s;
  logic        restart_s;
  logic        in_set_s;
  logic [5:0]  blank_s;

`ifdef AUTO_REPEAT_EN
  localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
  logic        rep_arm_r;
  logic        rep_arm_s;
  logic        rep_dir_r;   // 0 = inc, 1 = dec
  logic        rep_dir_s;
  logic [15:0] rep_cnt_r;
  logic [15:0] rep_cnt_s;
  logic        held_s;
`endif

  assign in_set_s = (state_r != ST_RUN);
  assign mode     = state_r;
  assign adj_sel  = state_r;

  // Next-state, timeout, auto-repeat, blink and blank computation.
  always_comb begin
    next_state_s = state_r;
    to_cnt_s     = to_cnt_r;
    up_s         = 1'b0;
    dn_s         = 1'b0;
    entry_s      = 1'b0;
    restart_s    = 1'b0;
    div_s        = div_r;
    phase_s      = phase_r;
    blank_s      = 6'b000000;
`ifdef AUTO_REPEAT_EN
    rep_arm_s    = 1'b0;
    rep_dir_s    = rep_dir_r;
    rep_cnt_s    = 16'd0;
    held_s       = 1'b0;
`endif

    // Mode advance has priority; any coincident adjust press is dropped.
    if (mode_press_s) begin
      case (state_r)
        ST_RUN:     next_state_s = ST_SET_HR;
        ST_SET_HR:  next_state_s = ST_SET_MIN;
        ST_SET_MIN: next_state_s = ST_SET_SEC;
        ST_SET_SEC: next_state_s = ST_RUN;
        default:    next_state_s = ST_RUN;
      endcase
      to_cnt_s = 8'd0;
      entry_s  = (next_state_s != ST_RUN);
    end else if (in_set_s) begin
      if (inc_press_s && !dec_press_s) begin
        up_s = 1'b1;
      end else if (dec_press_s && !inc_press_s) begin
        dn_s = 1'b1;
      end else begin
        up_s = 1'b0;
        dn_s = 1'b0;
      end
      // A press on the final tick wins over the timeout.
      if (inc_press_s || dec_press_s) begin
        to_cnt_s = 8'd0;
      end else if (tick_in) begin
        if (to_cnt_r == TO_LAST) begin
          next_state_s = ST_RUN;
          to_cnt_s     = 8'd0;
        end else begin
          to_cnt_s = to_cnt_r + 8'd1;
        end
      end else begin
        to_cnt_s = to_cnt_r;
      end
    end else begin
      to_cnt_s = 8'd0;
    end

`ifdef AUTO_REPEAT_EN
    // Repeats are armed by an initial strobe and continue only while the
    // same button alone stays accepted-low in an unchanged set state.
    if (rep_dir_r) begin
      held_s = !level_r[2] && level_r[1];
    end else begin
      held_s = !level_r[1] && level_r[2];
    end
    if (up_s || dn_s) begin
      rep_arm_s = 1'b1;
      rep_dir_s = dn_s;
      rep_cnt_s = 16'd0;
    end else if (rep_arm_r && in_set_s && (next_state_s == state_r) &&
                 !inc_press_s && !dec_press_s && held_s) begin
      rep_arm_s = 1'b1;
      if (rep_cnt_r == REP_LAST) begin
        rep_cnt_s = 16'd0;
        up_s      = !rep_dir_r;
        dn_s      = rep_dir_r;
        to_cnt_s  = 8'd0;
      end else begin
        rep_cnt_s = rep_cnt_r + 16'd1;
      end
    end else begin
      rep_arm_s = 1'b0;
      rep_cnt_s = 16'd0;
    end
`endif

    restart_s = entry_s || up_s || dn_s;

    if (next_state_s == ST_RUN) begin
      div_s   = 16'd0;
      phase_s = 1'b0;
    end else if (restart_s) begin
      div_s   = 16'd0;
      phase_s = 1'b0;
    end else if (div_r == BLINK_LAST) begin
      div_s   = 16'd0;
      phase_s = ~phase_r;
    end else begin
      div_s   = div_r + 16'd1;
      phase_s = phase_r;
    end

    case (next_state_s)
      ST_SET_HR:  blank_s = {phase_s, phase_s, 4'b0000};
      ST_SET_MIN: blank_s = {2'b00, phase_s, phase_s, 2'b00};
      ST_SET_SEC: blank_s = {4'b0000, phase_s, phase_s};
      default:    blank_s = 6'b000000;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r   <= ST_RUN;
      to_cnt_r  <= 8'd0;
      div_r     <= 16'd0;
      phase_r   <= 1'b0;
      run_en    <= 1'b1;
      adj_up    <= 1'b0;
      adj_dn    <= 1'b0;
      blank     <= 6'b000000;
`ifdef AUTO_REPEAT_EN
      rep_arm_r <= 1'b0;
      rep_dir_r <= 1'b0;
      rep_cnt_r <= 16'd0;
`endif
    end else begin
      state_r   <= next_state_s;
      to_cnt_r  <= to_cnt_s;
      div_r     <= div_s;
      phase_r   <= phase_s;
      run_en    <= (next_state_s == ST_RUN);
      adj_up    <= up_s;
      adj_dn    <= dn_s;
      blank     <= blank_s;
`ifdef AUTO_REPEAT_EN
      rep_arm_r <= rep_arm_s;
      rep_dir_r <= rep_dir_s;
      rep_cnt_r <= rep_cnt_s;
`endif
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (DB_COUNT=4, BLINK_DIV=8,
// TIMEOUT_TICKS=3, REPEAT_CYCLES=16). Inputs change 1 time unit after a
// rising edge; outputs are read at that point or counted on falling edges.
module tb_clock_set_ctrl;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       pb_mode_n = 1'b1;
  logic       pb_inc_n = 1'b1;
  logic       pb_dec_n = 1'b1;
  logic       tick_in = 1'b0;
  logic [1:0] mode;
  logic       run_en;
  logic [1:0] adj_sel;
  logic       adj_up;
  logic       adj_dn;
  logic [5:0] blank;

  int checks = 0;
  int failures = 0;

  int up_cnt = 0;
  int dn_cnt = 0;
  int cyc_n = 0;
  int last_up_cyc = 0;
  int last_gap = 0;
  logic [1:0] last_up_sel = 2'b00;

  clock_set_ctrl #(
    .DB_COUNT(4),
    .BLINK_DIV(8),
    .TIMEOUT_TICKS(3),
    .REPEAT_CYCLES(16)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .pb_mode_n(pb_mode_n),
    .pb_inc_n(pb_inc_n),
    .pb_dec_n(pb_dec_n),
    .tick_in(tick_in),
    .mode(mode),
    .run_en(run_en),
    .adj_sel(adj_sel),
    .adj_up(adj_up),
    .adj_dn(adj_dn),
    .blank(blank)
  );

  always #5 clk_in = ~clk_in;

  // Strobe monitor: counts pulses and records spacing / field of adj_up.
  always @(negedge clk_in) begin
    cyc_n = cyc_n + 1;
    if (adj_up) begin
      up_cnt      = up_cnt + 1;
      last_gap    = cyc_n - last_up_cyc;
      last_up_cyc = cyc_n;
      last_up_sel = adj_sel;
    end
    if (adj_dn) begin
      dn_cnt = dn_cnt + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: pb_mode_n = v;
      1: pb_inc_n  = v;
      default: pb_dec_n = v;
    endcase
  endtask

  task automatic tap(input int which, input int low_n, input int high_n);
    set_btn(which, 1'b0);
    step(low_n);
    set_btn(which, 1'b1);
    step(high_n);
  endtask

  task automatic do_reset();
    pb_mode_n = 1'b1;
    pb_inc_n  = 1'b1;
    pb_dec_n  = 1'b1;
    tick_in   = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    int base_up;
    int base_dn;
    base_up = up_cnt;
    base_dn = dn_cnt;
    do_reset();
    checks++; if (mode !== 2'b00) begin failures++; $display("FAIL reset_mode got=%b exp=00", mode); end
    checks++; if (run_en !== 1'b1) begin failures++; $display("FAIL reset_run_en got=%b exp=1", run_en); end
    checks++; if (blank !== 6'b000000) begin failures++; $display("FAIL reset_blank got=%b exp=000000", blank); end
    checks++; if (adj_sel !== 2'b00) begin failures++; $display("FAIL reset_adj_sel got=%b exp=00", adj_sel); end
    checks++; if ((up_cnt - base_up) + (dn_cnt - base_dn) !== 0) begin
      failures++; $display("FAIL reset_strobes got=%0d exp=0", (up_cnt - base_up) + (dn_cnt - base_dn));
    end
  endtask

  task automatic test_mode_step();
    do_reset();
    pb_mode_n = 1'b0;
    step(6);
    checks++; if (mode !== 2'b00) begin failures++; $display("FAIL mode_early got=%b exp=00", mode); end
    step(1);
    checks++; if (mode !== 2'b01) begin failures++; $display("FAIL mode_hr got=%b exp=01", mode); end
    checks++; if (run_en !== 1'b0) begin failures++; $display("FAIL mode_hr_run_en got=%b exp=0", run_en); end
    checks++; if (adj_sel !== 2'b01) begin failures++; $display("FAIL mode_hr_sel got=%b exp=01", adj_sel); end
    pb_mode_n = 1'b1;
    step(12);
    tap(0, 10, 10);
    checks++; if (mode !== 2'b10) begin failures++; $display("FAIL mode_min got=%b exp=10", mode); end
    tap(0, 10, 10);
    checks++; if (mode !== 2'b11) begin failures++; $display("FAIL mode_sec got=%b exp=11", mode); end
    tap(0, 10, 10);
    checks++; if (mode !== 2'b00) begin failures++; $display("FAIL mode_wrap got=%b exp=00", mode); end
    checks++; if (run_en !== 1'b1) begin failures++; $display("FAIL mode_wrap_run_en got=%b exp=1", run_en); end
  endtask

  task automatic test_adjust();
    int base_up;
    int base_dn;
    int exp_up;
`ifdef AUTO_REPEAT_EN
    exp_up = 2;   // initial strobe plus one repeat before release settles
`else
    exp_up = 1;
`endif
    do_reset();
    // inc in RUN is ignored
    base_up = up_cnt;
    tap(1, 10, 10);
    checks++; if (up_cnt - base_up !== 0) begin failures++; $display("FAIL run_inc_ignored got=%0d exp=0", up_cnt - base_up); end
    tap(0, 10, 10);
    tap(0, 10, 10);
    checks++; if (mode !== 2'b10) begin failures++; $display("FAIL adj_enter_min got=%b exp=10", mode); end
    base_up = up_cnt;
    base_dn = dn_cnt;
    tap(1, 3, 15);
    checks++; if (up_cnt - base_up !== 0) begin failures++; $display("FAIL glitch_inc got=%0d exp=0", up_cnt - base_up); end
    tap(1, 20, 15);
    checks++; if (up_cnt - base_up !== exp_up) begin failures++; $display("FAIL inc_hold got=%0d exp=%0d", up_cnt - base_up, exp_up); end
    checks++; if (last_up_sel !== 2'b10) begin failures++; $display("FAIL inc_sel got=%b exp=10", last_up_sel); end
    checks++; if (dn_cnt - base_dn !== 0) begin failures++; $display("FAIL inc_no_dn got=%0d exp=0", dn_cnt - base_dn); end
    tap(2, 10, 10);
    checks++; if (dn_cnt - base_dn !== 1) begin failures++; $display("FAIL dec_press got=%0d exp=1", dn_cnt - base_dn); end
  endtask

  task automatic test_blink_timeout();
    do_reset();
    pb_mode_n = 1'b0;
    step(7);   // set-state entry edge E
    checks++; if (mode !== 2'b01) begin failures++; $display("FAIL blink_enter got=%b exp=01", mode); end
    checks++; if (blank !== 6'b000000) begin failures++; $display("FAIL blink_e0 got=%b exp=000000", blank); end
    pb_mode_n = 1'b1;
    step(7);
    checks++; if (blank !== 6'b000000) begin failures++; $display("FAIL blink_e7 got=%b exp=000000", blank); end
    step(1);
    checks++; if (blank !== 6'b110000) begin failures++; $display("FAIL blink_e8 got=%b exp=110000", blank); end
    step(7);
    checks++; if (blank !== 6'b110000) begin failures++; $display("FAIL blink_e15 got=%b exp=110000", blank); end
    step(1);
    checks++; if (blank !== 6'b000000) begin failures++; $display("FAIL blink_e16 got=%b exp=000000", blank); end
    step(8);
    checks++; if (blank !== 6'b110000) begin failures++; $display("FAIL blink_e24 got=%b exp=110000", blank); end
    for (int t = 0; t < 2; t++) begin
      tick_in = 1'b1;
      step(1);
      tick_in = 1'b0;
      step(3);
    end
    checks++; if (mode !== 2'b01) begin failures++; $display("FAIL timeout_early got=%b exp=01", mode); end
    tick_in = 1'b1;
    step(1);
    tick_in = 1'b0;
    checks++; if (mode !== 2'b00) begin failures++; $display("FAIL timeout_mode got=%b exp=00", mode); end
    checks++; if (run_en !== 1'b1) begin failures++; $display("FAIL timeout_run_en got=%b exp=1", run_en); end
    checks++; if (blank !== 6'b000000) begin failures++; $display("FAIL timeout_blank got=%b exp=000000", blank); end
  endtask

  task automatic test_same_cycle();
    int base_up;
    int base_dn;
    do_reset();
    tap(0, 10, 10);
    base_up = up_cnt;
    base_dn = dn_cnt;
    pb_inc_n = 1'b0;
    pb_dec_n = 1'b0;
    step(12);
    pb_inc_n = 1'b1;
    pb_dec_n = 1'b1;
    step(10);
    checks++; if ((up_cnt - base_up) + (dn_cnt - base_dn) !== 0) begin
      failures++; $display("FAIL inc_dec_both got=%0d exp=0", (up_cnt - base_up) + (dn_cnt - base_dn));
    end
    checks++; if (mode !== 2'b01) begin failures++; $display("FAIL inc_dec_mode got=%b exp=01", mode); end
    pb_mode_n = 1'b0;
    pb_inc_n  = 1'b0;
    step(7);
    checks++; if (mode !== 2'b10) begin failures++; $display("FAIL mode_inc_mode got=%b exp=10", mode); end
    step(10);
    pb_mode_n = 1'b1;
    pb_inc_n  = 1'b1;
    step(10);
    checks++; if (up_cnt - base_up !== 0) begin failures++; $display("FAIL mode_inc_strobe got=%0d exp=0", up_cnt - base_up); end
  endtask

  task automatic test_reset_abort();
    int base_up;
    do_reset();
    tap(0, 10, 10);
    tap(0, 10, 10);
    tap(0, 10, 10);
    checks++; if (mode !== 2'b11) begin failures++; $display("FAIL abort_sec got=%b exp=11", mode); end
    base_up = up_cnt;
    pb_inc_n = 1'b0;
    step(6);   // press pulse now pending for the next edge
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (mode !== 2'b00) begin failures++; $display("FAIL abort_mode got=%b exp=00", mode); end
    checks++; if (run_en !== 1'b1) begin failures++; $display("FAIL abort_run_en got=%b exp=1", run_en); end
    checks++; if (adj_up !== 1'b0) begin failures++; $display("FAIL abort_adj_up got=%b exp=0", adj_up); end
    step(15);
    pb_inc_n = 1'b1;
    step(10);
    checks++; if (up_cnt - base_up !== 0) begin failures++; $display("FAIL abort_no_up got=%0d exp=0", up_cnt - base_up); end
  endtask

`ifdef AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int base_up;
    do_reset();
    tap(0, 10, 10);
    base_up = up_cnt;
    pb_inc_n = 1'b0;
    step(7);
    checks++; if (adj_up !== 1'b1) begin failures++; $display("FAIL rep_first got=%b exp=1", adj_up); end
    step(50);
    checks++; if (up_cnt - base_up !== 4) begin failures++; $display("FAIL rep_count got=%0d exp=4", up_cnt - base_up); end
    checks++; if (last_gap !== 16) begin failures++; $display("FAIL rep_gap got=%0d exp=16", last_gap); end
    pb_inc_n = 1'b1;
    step(20);
    checks++; if (up_cnt - base_up !== 4) begin failures++; $display("FAIL rep_release got=%0d exp=4", up_cnt - base_up); end
  endtask
`endif

  initial begin
    test_reset();
    test_mode_step();
    test_adjust();
    test_blink_timeout();
    test_same_cycle();
    test_reset_abort();
`ifdef AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
